// File: rtl/dlx_pkg.sv
// Shared encodings for the DLX multi-cycle controller: opcodes, FSM states,
// datapath mux selects and the immediate-opcode to ALU function map.
package dlx_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpFparith = 6'h01;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeqz    = 6'h04;
  localparam logic [5:0] OpBnez    = 6'h05;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddui   = 6'h09;
  localparam logic [5:0] OpSubi    = 6'h0a;
  localparam logic [5:0] OpSubui   = 6'h0b;
  localparam logic [5:0] OpAndi    = 6'h0c;
  localparam logic [5:0] OpOri     = 6'h0d;
  localparam logic [5:0] OpXori    = 6'h0e;
  localparam logic [5:0] OpLhi     = 6'h0f;
  localparam logic [5:0] OpJr      = 6'h12;
  localparam logic [5:0] OpJalr    = 6'h13;
  localparam logic [5:0] OpSlli    = 6'h14;
  localparam logic [5:0] OpSrli    = 6'h16;
  localparam logic [5:0] OpSrai    = 6'h17;
  localparam logic [5:0] OpSeqi    = 6'h18;
  localparam logic [5:0] OpSnei    = 6'h19;
  localparam logic [5:0] OpSlti    = 6'h1a;
  localparam logic [5:0] OpSgti    = 6'h1b;
  localparam logic [5:0] OpSlei    = 6'h1c;
  localparam logic [5:0] OpSgei    = 6'h1d;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2b;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StErr    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ClsAluR, ClsAluI, ClsBeqz, ClsBnez, ClsJImm, ClsJReg, ClsLoad, ClsStore
  } op_cls_e;

  localparam logic [1:0] MemByte = 2'd0;
  localparam logic [1:0] MemHalf = 2'd1;
  localparam logic [1:0] MemWord = 2'd2;

  localparam logic [1:0] WbAlu  = 2'd0;
  localparam logic [1:0] WbMem  = 2'd1;
  localparam logic [1:0] WbLink = 2'd2;
  localparam logic [1:0] WbLhi  = 2'd3;

  localparam logic [1:0] PcNpc    = 2'd0;
  localparam logic [1:0] PcBranch = 2'd1;
  localparam logic [1:0] PcJimm   = 2'd2;
  localparam logic [1:0] PcReg    = 2'd3;

  localparam logic [5:0] FnAdd = 6'h20;

  // Unmapped immediate opcodes fall back to the instruction's own function field.
  function automatic logic [5:0] imm_func(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      OpAddi:  imm_func = 6'h20;
      OpAddui: imm_func = 6'h21;
      OpSubi:  imm_func = 6'h22;
      OpSubui: imm_func = 6'h23;
      OpAndi:  imm_func = 6'h24;
      OpOri:   imm_func = 6'h25;
      OpXori:  imm_func = 6'h26;
      OpSlli:  imm_func = 6'h04;
      OpSrli:  imm_func = 6'h06;
      OpSrai:  imm_func = 6'h07;
      OpSeqi:  imm_func = 6'h28;
      OpSnei:  imm_func = 6'h29;
      OpSlti:  imm_func = 6'h2a;
      OpSgti:  imm_func = 6'h2b;
      OpSlei:  imm_func = 6'h2c;
      OpSgei:  imm_func = 6'h2d;
      default: imm_func = fn;
    endcase
  endfunction

endpackage

// File: rtl/dlx_op_decode.sv
// Combinational decode of the latched instruction into op class and the
// per-instruction attributes the sequencer needs.
module dlx_op_decode
  import dlx_pkg::*;
#(
  parameter int unsigned INST_W = 32
) (
  input  logic [INST_W-1:0] ir,
  output logic [2:0]        op_cls,
  output logic [1:0]        size,
  output logic              sign,
  output logic              link,
  output logic              lhi,
  output logic              zext
);

  logic [5:0] op;
  logic       unused_ir;

  assign op        = ir[INST_W-1:INST_W-6];
  assign unused_ir = ^ir[INST_W-7:0];

  always_comb begin
    op_cls = ClsAluI;
    size   = MemWord;
    sign   = 1'b1;
    link   = 1'b0;
    lhi    = 1'b0;
    zext   = 1'b0;
    case (op)
      OpSpecial, OpFparith: op_cls = ClsAluR;
      OpBeqz:               op_cls = ClsBeqz;
      OpBnez:               op_cls = ClsBnez;
      OpJ:                  op_cls = ClsJImm;
      OpJal: begin
        op_cls = ClsJImm;
        link   = 1'b1;
      end
      OpJr:                 op_cls = ClsJReg;
      OpJalr: begin
        op_cls = ClsJReg;
        link   = 1'b1;
      end
      OpLb: begin
        op_cls = ClsLoad;
        size   = MemByte;
      end
      OpLbu: begin
        op_cls = ClsLoad;
        size   = MemByte;
        sign   = 1'b0;
      end
      OpLh: begin
        op_cls = ClsLoad;
        size   = MemHalf;
      end
      OpLhu: begin
        op_cls = ClsLoad;
        size   = MemHalf;
        sign   = 1'b0;
      end
      OpLw:                 op_cls = ClsLoad;
      OpSb: begin
        op_cls = ClsStore;
        size   = MemByte;
      end
      OpSh: begin
        op_cls = ClsStore;
        size   = MemHalf;
      end
      OpSw:                 op_cls = ClsStore;
      OpLhi:                lhi    = 1'b1;
      OpAddui, OpSubui, OpAndi, OpOri, OpXori: zext = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/dlx_mc_ctrl.sv
// Multi-cycle DLX control sequencer: FETCH/DECODE/EXEC/MEM/WB over a shared
// req/ack memory port, with a wait-cycle timeout that parks the FSM in ERR.
module dlx_mc_ctrl
  import dlx_pkg::*;
#(
  parameter int unsigned INST_W      = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic              zero,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic              ir_wr,
  output logic              pc_wr,
  output logic [1:0]        pc_src,
  output logic              reg_wr,
  output logic [1:0]        wb_sel,
  output logic              load_signed,
  output logic              alu_imm,
  output logic              imm_zext,
  output logic [5:0]        func_code,
  output logic              instr_done,
  output logic              err,
  output logic [2:0]        state
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [2:0] dec_cls;
  op_cls_e    cls;
  logic [1:0] dec_size;
  logic       dec_sign, dec_link, dec_lhi, dec_zext;
  logic       mem_wait, timeout;

  dlx_op_decode #(
    .INST_W (INST_W)
  ) u_decode (
    .ir     (ir_q),
    .op_cls (dec_cls),
    .size   (dec_size),
    .sign   (dec_sign),
    .link   (dec_link),
    .lhi    (dec_lhi),
    .zext   (dec_zext)
  );

  assign cls = op_cls_e'(dec_cls);

  // Ack on the limit cycle wins over the timeout.
  assign mem_wait = ((state_q == StFetch) || (state_q == StMem)) && !mem_ack;
  assign timeout  = mem_wait && (cnt_q == CntW'(MEM_TIMEOUT - 1));
  assign cnt_d    = (mem_wait && !timeout) ? cnt_q + CntW'(1) : '0;
  assign ir_d     = ((state_q == StFetch) && mem_ack) ? mem_rdata : ir_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ack)      state_d = StDecode;
        else if (timeout) state_d = StErr;
      end
      StDecode: state_d = StExec;
      StExec: begin
        case (cls)
          ClsBeqz, ClsBnez: state_d = StFetch;
          ClsJImm, ClsJReg: state_d = dec_link ? StWb : StFetch;
          ClsLoad, ClsStore: state_d = StMem;
          default:          state_d = StWb;
        endcase
      end
      StMem: begin
        if (mem_ack)      state_d = (cls == ClsStore) ? StFetch : StWb;
        else if (timeout) state_d = StErr;
      end
      StWb:    state_d = StFetch;
      StErr:   state_d = StErr;
      default: state_d = StFetch;
    endcase
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_size    = MemByte;
    ir_wr       = 1'b0;
    pc_wr       = 1'b0;
    pc_src      = PcNpc;
    reg_wr      = 1'b0;
    wb_sel      = WbAlu;
    load_signed = 1'b0;
    alu_imm     = 1'b0;
    imm_zext    = 1'b0;
    func_code   = '0;
    instr_done  = 1'b0;
    err         = 1'b0;
    state       = 3'd0;
    if (!reset) begin
      state = state_q;
      case (state_q)
        StFetch: begin
          mem_req  = 1'b1;
          mem_size = MemWord;
          ir_wr    = mem_ack;
        end
        StExec: begin
          pc_wr = 1'b1;
          case (cls)
            ClsAluR: func_code = ir_q[5:0];
            ClsAluI: begin
              alu_imm   = 1'b1;
              imm_zext  = dec_zext;
              func_code = imm_func(ir_q[INST_W-1:INST_W-6], ir_q[5:0]);
            end
            ClsBeqz: begin
              pc_src     = zero ? PcBranch : PcNpc;
              instr_done = 1'b1;
            end
            ClsBnez: begin
              pc_src     = zero ? PcNpc : PcBranch;
              instr_done = 1'b1;
            end
            ClsJImm: begin
              pc_src     = PcJimm;
              instr_done = !dec_link;
            end
            ClsJReg: begin
              pc_src     = PcReg;
              instr_done = !dec_link;
            end
            default: begin
              alu_imm   = 1'b1;
              func_code = FnAdd;
            end
          endcase
        end
        StMem: begin
          mem_req    = 1'b1;
          mem_we     = (cls == ClsStore);
          mem_size   = dec_size;
          instr_done = mem_ack && (cls == ClsStore);
        end
        StWb: begin
          reg_wr      = 1'b1;
          instr_done  = 1'b1;
          load_signed = dec_sign;
          if (cls == ClsLoad) wb_sel = WbMem;
          else if (dec_link)  wb_sel = WbLink;
          else if (dec_lhi)   wb_sel = WbLhi;
          else                wb_sel = WbAlu;
        end
        StErr:   err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_mc_ctrl.sv
// Scoreboard bench for dlx_mc_ctrl: per-instruction expectations from an
// ISA-level model, checked by an independent monitor on each instr_done.
module tb_dlx_mc_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        zero;
  logic        mem_req, mem_we, ir_wr, pc_wr, reg_wr, load_signed;
  logic        alu_imm, imm_zext, instr_done, err;
  logic [1:0]  mem_size, pc_src, wb_sel;
  logic [5:0]  func_code;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  dlx_mc_ctrl #(
    .INST_W      (32),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .zero        (zero),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_size    (mem_size),
    .ir_wr       (ir_wr),
    .pc_wr       (pc_wr),
    .pc_src      (pc_src),
    .reg_wr      (reg_wr),
    .wb_sel      (wb_sel),
    .load_signed (load_signed),
    .alu_imm     (alu_imm),
    .imm_zext    (imm_zext),
    .func_code   (func_code),
    .instr_done  (instr_done),
    .err         (err),
    .state       (state)
  );

  typedef struct {
    int          plen;
    logic [63:0] path;
    logic [1:0]  pcs;
    int          nreg;
    logic [1:0]  wbs;
    logic        lsg;
    bit          chk_mem;
    logic        we;
    logic [1:0]  sz;
    bit          chk_alu;
    logic        aimm;
    logic        zx;
    logic [5:0]  fc;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] all_outs();
    return {mem_req, mem_we, mem_size, ir_wr, pc_wr, pc_src, reg_wr, wb_sel, load_signed,
            alu_imm, imm_zext, func_code, instr_done, err, state};
  endfunction

  function automatic logic [5:0] ifunc(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h08: return 6'h20;  6'h09: return 6'h21;  6'h0a: return 6'h22;
      6'h0b: return 6'h23;  6'h0c: return 6'h24;  6'h0d: return 6'h25;
      6'h0e: return 6'h26;  6'h14: return 6'h04;  6'h16: return 6'h06;
      6'h17: return 6'h07;  6'h18: return 6'h28;  6'h19: return 6'h29;
      6'h1a: return 6'h2a;  6'h1b: return 6'h2b;  6'h1c: return 6'h2c;
      6'h1d: return 6'h2d;
      default: return fn;
    endcase
  endfunction

  // ISA-level expectation: state path, PC source, write-back and memory attributes.
  function automatic exp_t model(input logic [31:0] inst, input int df, input int dm,
                                 input logic z);
    exp_t e;
    logic [5:0] op = inst[31:26];
    bit is_r  = (op == 6'h00) || (op == 6'h01);
    bit is_ld = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    bit is_st = op inside {6'h28, 6'h29, 6'h2b};
    bit is_br = op inside {6'h04, 6'h05};
    bit is_j  = op inside {6'h02, 6'h12};
    bit is_lk = op inside {6'h03, 6'h13};
    bit is_ai = !(is_r || is_ld || is_st || is_br || is_j || is_lk);
    e.plen = 0;
    e.path = '0;
    for (int i = 0; i <= df; i++) begin e.path = {e.path[60:0], 3'd0}; e.plen++; end
    e.path = {e.path[57:0], 3'd1, 3'd2};
    e.plen += 2;
    if (is_ld || is_st)
      for (int i = 0; i <= dm; i++) begin e.path = {e.path[60:0], 3'd3}; e.plen++; end
    e.nreg = (is_r || is_ai || is_lk || is_ld) ? 1 : 0;
    if (e.nreg == 1) begin e.path = {e.path[60:0], 3'd4}; e.plen++; end
    if (op == 6'h04)                   e.pcs = z ? 2'd1 : 2'd0;
    else if (op == 6'h05)              e.pcs = z ? 2'd0 : 2'd1;
    else if (op inside {6'h02, 6'h03}) e.pcs = 2'd2;
    else if (op inside {6'h12, 6'h13}) e.pcs = 2'd3;
    else                               e.pcs = 2'd0;
    e.wbs     = is_ld ? 2'd1 : is_lk ? 2'd2 : (op == 6'h0f) ? 2'd3 : 2'd0;
    e.lsg     = !(op inside {6'h24, 6'h25});
    e.chk_mem = is_ld || is_st;
    e.we      = is_st;
    e.sz      = (op inside {6'h20, 6'h24, 6'h28}) ? 2'd0 :
                (op inside {6'h21, 6'h25, 6'h29}) ? 2'd1 : 2'd2;
    e.chk_alu = is_r || is_ai || is_ld || is_st;
    e.aimm    = !is_r;
    e.zx      = is_ai && (op inside {6'h09, 6'h0b, 6'h0c, 6'h0d, 6'h0e});
    e.fc      = is_r ? inst[5:0] : (is_ld || is_st) ? 6'h20 : ifunc(op, inst[5:0]);
    return e;
  endfunction

  // Monitor: accumulate what the DUT does per instruction, compare on instr_done.
  initial begin
    int          o_plen, o_npc, o_nreg;
    logic [63:0] o_path;
    logic [1:0]  o_pcs, o_wbs, o_sz;
    logic        o_lsg, o_we, o_aimm, o_zx, o_badwe;
    logic [5:0]  o_fc;
    exp_t        e;
    forever begin
      @(negedge clk);
      #3;
      if (!mon_en || reset) begin
        o_plen = 0; o_path = '0; o_npc = 0; o_nreg = 0; o_badwe = 0;
        o_pcs = '0; o_wbs = '0; o_sz = '0; o_lsg = 0; o_we = 0; o_aimm = 0; o_zx = 0;
        o_fc = '0;
      end else begin
        o_path = {o_path[60:0], state};
        o_plen++;
        if (pc_wr) begin o_npc++; o_pcs = pc_src; end
        if (reg_wr) begin o_nreg++; o_wbs = wb_sel; o_lsg = load_signed; end
        if (state == 3'd2) begin o_aimm = alu_imm; o_zx = imm_zext; o_fc = func_code; end
        if (state == 3'd3) begin o_we = mem_we; o_sz = mem_size; end
        else if (mem_we) o_badwe = 1'b1;
        if (instr_done) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got instr_done expected none");
          end else begin
            e = sb.pop_front();
            check("latency", 64'(o_plen), 64'(e.plen));
            check("state_path", o_path, e.path);
            check("pc_wr_count", 64'(o_npc), 64'd1);
            check("pc_src", 64'(o_pcs), 64'(e.pcs));
            check("reg_wr_count", 64'(o_nreg), 64'(e.nreg));
            check("mem_we_outside_mem", 64'(o_badwe), 64'd0);
            if (e.nreg == 1) begin
              check("wb_sel", 64'(o_wbs), 64'(e.wbs));
              check("load_signed", 64'(o_lsg), 64'(e.lsg));
            end
            if (e.chk_mem) begin
              check("mem_we", 64'(o_we), 64'(e.we));
              check("mem_size", 64'(o_sz), 64'(e.sz));
            end
            if (e.chk_alu) begin
              check("alu_imm", 64'(o_aimm), 64'(e.aimm));
              check("imm_zext", 64'(o_zx), 64'(e.zx));
              check("func_code", 64'(o_fc), 64'(e.fc));
            end
          end
          o_plen = 0; o_path = '0; o_npc = 0; o_nreg = 0; o_badwe = 0;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the instruction completes.
  task automatic run_instr(input logic [31:0] inst, input int df, input int dm, input logic z);
    int ph = 0;
    int w = 0;
    int bud = 0;
    bit done = 0;
    sb.push_back(model(inst, df, dm, z));
    zero = z;
    while (!done) begin
      #1;
      mem_rdata = (ph == 0) ? inst : $urandom;
      if (mem_req) begin
        mem_ack = (w == ((ph == 0) ? df : dm));
        if (mem_ack) begin ph++; w = 0; end
        else w++;
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      #1;
      done = instr_done;
      @(negedge clk);
      bud++;
      if (!done && bud > 40) begin
        checks++;
        errors++;
        $display("FAIL instr_budget: got no instr_done in %0d cycles expected done", bud);
        done = 1;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    mem_ack = 1'b1;
    zero    = 1'b1;
    #1;
    check("reset_outputs_zero", 64'(all_outs()), 64'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    reset   = 1'b0;
  endtask

  logic [5:0] ops [36];

  initial begin
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c,
            6'h0d, 6'h0e, 6'h0f, 6'h12, 6'h13, 6'h14, 6'h16, 6'h17, 6'h18, 6'h19, 6'h1a,
            6'h1b, 6'h1c, 6'h1d, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b,
            6'h06, 6'h3f, 6'h30};
    mem_rdata = '0;
    mem_ack   = 1'b0;
    zero      = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    do_reset();
    #1;
    check("post_reset_state", 64'(state), 64'd0);
    check("post_reset_req", 64'(mem_req), 64'd1);
    @(negedge clk);
    do_reset();

    mon_en = 1'b1;
    run_instr(32'h0022_1820, 0, 0, 1'b0);            // ADD
    run_instr(32'h9000_0000 | 32'h0003_0004, 0, 3, 1'b0);  // LBU, 3 wait cycles
    run_instr(32'h1420_0008, 0, 0, 1'b0);            // BNEZ taken
    run_instr(32'h1420_0008, 0, 0, 1'b1);            // BNEZ not taken
    run_instr(32'h0c00_0010, 0, 0, 1'b0);            // JAL
    for (int n = 0; n < 80; n++) begin
      logic [31:0] inst;
      inst = $urandom;
      inst[31:26] = ops[$urandom_range(0, 35)];
      run_instr(inst, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                1'($urandom_range(0, 1)));
    end
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    // Fetch timeout into ERR; later acks ignored; reset recovers.
    mon_en = 1'b0;
    do_reset();
    for (int i = 0; i < int'(TO); i++) begin
      #1;
      check("fetch_waiting", 64'({state, mem_req}), 64'({3'd0, 1'b1}));
      @(negedge clk);
    end
    #1;
    check("err_entered", 64'({state, err, mem_req}), 64'({3'd5, 1'b1, 1'b0}));
    mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("err_ignores_ack", 64'(all_outs()), 64'({24'd0, 1'b0} | (25'd1 << 3) | 25'd5));
    @(negedge clk);
    do_reset();
    #1;
    check("err_cleared", 64'({state, err, mem_req}), 64'({3'd0, 1'b0, 1'b1}));
    @(negedge clk);

    // Reset during the MEM phase of SW abandons the store.
    do_reset();
    mem_rdata = 32'hac22_0004;
    mem_ack   = 1'b1;
    #1;
    check("sw_fetch_ir_wr", 64'(ir_wr), 64'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("sw_in_mem", 64'({state, mem_we, mem_size}), 64'({3'd3, 1'b1, 2'd2}));
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("no_we_after_reset", 64'({state, mem_we}), 64'({3'd0, 1'b0}));
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dlx_mc_ctrl.md
# dlx_mc_ctrl

Multi-cycle control sequencer for the DLX datapath. It replaces the purely combinational per-instruction decode with an FSM that sequences fetch, decode, execute, memory and write-back over several cycles. It drives a single shared memory port through a req/ack handshake with a parametrised timeout. It sits between the instruction/data memory interface and the register file, ALU and PC logic.

## Interface
- `INST_W`, 32, instruction width; opcode is always `[INST_W-1:INST_W-6]`, function code `[5:0]`
- `MEM_TIMEOUT`, 16, max cycles `mem_req` may wait for `mem_ack` before error; ≥1
- `clk` in 1: sole clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `mem_rdata` in INST_W: memory read data, used as instruction during FETCH
- `mem_ack` in 1: memory completes current request this cycle
- `zero` in 1: datapath flag, busA == 0
- `mem_req` out 1: memory request, held until ack
- `mem_we` out 1: request is a write
- `mem_size` out 2: 0 byte, 1 half, 2 word
- `ir_wr` out 1: latch instruction and NPC (PC+4) in datapath
- `pc_wr` out 1: update PC
- `pc_src` out 2: 0 NPC, 1 branch target, 2 jump immediate, 3 register busA
- `reg_wr` out 1: register-file write strobe
- `wb_sel` out 2: 0 ALU, 1 memory, 2 NPC (link), 3 LHI value
- `load_signed` out 1: sign-extend sub-word load
- `alu_imm` out 1: ALU B operand is immediate
- `imm_zext` out 1: zero-extend immediate
- `func_code` out 6: ALU function
- `instr_done` out 1: one-cycle pulse on final cycle of each instruction
- `err` out 1: sticky memory-timeout flag
- `state` out 3: current FSM state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5. Codes 6 and 7 are unreachable and go to FETCH.
- FETCH
  - `mem_req=1`, `mem_we=0`, `mem_size=2`.
  - On `mem_ack`: `ir_wr=1` and the internal IR captures `mem_rdata` in the same cycle. Next state DECODE.
- DECODE: one cycle, no strobes. The op class is computed from IR.
- EXEC: one cycle; `alu_imm`, `imm_zext`, `func_code` valid.
  - R-type (opcode 0x00/0x01): `alu_imm=0`, `func_code=IR[5:0]`, `pc_wr=1`, `pc_src=0`. Next WB.
  - ALU immediate and LHI (0x08–0x1d): `alu_imm=1`, `pc_wr=1`, `pc_src=0`. Next WB.
    - `imm_zext=1` for ADDUI/SUBUI/ANDI/ORI/XORI.
    - `func_code` follows the opcode→func map in `dlx_pkg`.
  - BEQZ/BNEZ: `pc_wr=1`, `pc_src` = 1 if taken (BEQZ: `zero`=1; BNEZ: `zero`=0), else 0. `instr_done=1`. Next FETCH.
  - J/JR: `pc_wr=1`, `pc_src` = 2 or 3 respectively. `instr_done=1`. Next FETCH.
  - JAL/JALR: same PC update as J/JR. Next WB with link.
  - Loads/stores (0x20–0x2b): `alu_imm=1`, `func_code=0x20`, `pc_wr=1`, `pc_src=0`. Next MEM.
  - Any other opcode: treated as ALU immediate with `func_code=IR[5:0]`.
- MEM
  - `mem_req=1`; `mem_we=1` for SB/SH/SW.
  - `mem_size`: byte for LB/LBU/SB, half for LH/LHU/SH, word otherwise.
  - On ack: store → `instr_done=1`, next FETCH; load → next WB.
- WB: one cycle, `reg_wr=1`, `instr_done=1`, next FETCH.
  - `wb_sel`: 1 for loads, 2 for JAL/JALR, 3 for LHI, 0 otherwise.
  - `load_signed=0` for LBU/LHU, 1 otherwise.
- Timeout
  - A counter increments every cycle `mem_req=1` without `mem_ack`, and clears on ack or when leaving FETCH/MEM.
  - When the counter reaches `MEM_TIMEOUT` with no ack that cycle, next state is ERR.
  - An ack arriving in the same cycle as the limit wins.
- ERR: all strobes and `mem_req` are 0 and `err=1`. The FSM stays in ERR until reset.
- `mem_ack` while `mem_req=0` is ignored.

## Timing
- All outputs are combinational from state, IR, `zero` and `mem_ack`. State, IR and counter are registered.
- Reset
  - In any cycle with `reset=1`: every output is 0 and `state=0`.
  - Next state FETCH; IR=0; counter=0; `err` cleared.
  - Reset mid-instruction abandons the instruction; no partial write occurs after the reset cycle.
- Latency with zero-wait memory (ack in the request cycle):
  - ALU or link: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch, J, JR: 3 cycles
- Each memory wait cycle adds 1 cycle.
- Exactly one `instr_done` pulse per instruction.
- `pc_wr` occurs exactly once per instruction, in EXEC. The datapath supplies the link value from NPC latched at `ir_wr`.

## Structure
- `dlx_pkg` holds:
  - opcode localparams
  - state enum
  - `mem_size`, `wb_sel` and `pc_src` encodings
  - the imm-opcode→func_code map function
- Sub-module `dlx_op_decode`: combinational decode of IR into op class, size, sign, link, LHI and zext. It is instantiated once inside `dlx_mc_ctrl`.

## Test plan
- ADD R-type (IR=0x00221820), ack immediate → states 0,1,2,4,0; `reg_wr` only in WB; `func_code=0x20`; `instr_done` at cycle 4.
- LBU (0x90...) with ack delayed 3 cycles in MEM → `mem_size=0`, `mem_we=0`, `load_signed=0`, `wb_sel=1`; total 8 cycles.
- BNEZ with `zero=0` then `zero=1` → `pc_src`=1 then 0; `reg_wr` never asserted; 3 cycles each.
- JAL → `pc_src=2` in EXEC, then WB with `wb_sel=2`, `reg_wr=1`.
- No ack for `MEM_TIMEOUT`=4 cycles in FETCH → `state=5`, `err=1`, `mem_req=0`; subsequent ack ignored; reset → FETCH, `err=0`.
- Reset asserted during MEM of SW → no `mem_we` after the reset cycle; restart in FETCH.
